// File: rtl/sys_bus_rr.sv
// sys_bus_rr: N-host to M-device single-outstanding bus with round-robin
// host arbitration and base/mask address decode.
// Optional response watchdog: define SYS_BUS_RR_TIMEOUT_EN.
module sys_bus_rr #(
  parameter int NrHosts       = 2,
  parameter int NrDevices     = 4,
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int TimeoutCycles = 256
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  // host side
  input  logic [NrHosts-1:0]                       host_req_i,
  input  logic [NrHosts-1:0]                       host_we_i,
  input  logic [NrHosts-1:0][AddressWidth-1:0]     host_addr_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]      host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]        host_wdata_i,
  output logic [NrHosts-1:0]                       host_gnt_o,
  output logic [NrHosts-1:0]                       host_rvalid_o,
  output logic [NrHosts-1:0]                       host_err_o,
  output logic [NrHosts-1:0][DataWidth-1:0]        host_rdata_o,
  // device side
  output logic [NrDevices-1:0]                     device_req_o,
  output logic [NrDevices-1:0][AddressWidth-1:0]   device_addr_o,
  output logic [NrDevices-1:0]                     device_we_o,
  output logic [NrDevices-1:0][DataWidth/8-1:0]    device_be_o,
  output logic [NrDevices-1:0][DataWidth-1:0]      device_wdata_o,
  input  logic [NrDevices-1:0]                     device_rvalid_i,
  input  logic [NrDevices-1:0]                     device_err_i,
  input  logic [NrDevices-1:0][DataWidth-1:0]      device_rdata_i,
  // decode map
  input  logic [NrDevices-1:0][AddressWidth-1:0]   cfg_device_addr_base_i,
  input  logic [NrDevices-1:0][AddressWidth-1:0]   cfg_device_addr_mask_i
);

  localparam int HW  = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int DIW = (NrDevices > 1) ? $clog2(NrDevices) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_RSP, ERR_RSP} state_e;

  state_e         state_q, state_d;
  logic [HW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]  host_q, host_d;     // host owning the outstanding transaction
  logic [DIW-1:0] dev_q, dev_d;       // device serving it

  logic           arb_valid;
  logic [HW-1:0]  arb_idx;
  logic           dec_hit;
  logic [DIW-1:0] dec_idx;
  logic           rsp_valid;
  logic           timeout;

  // Round-robin pick: walk downward so the host closest to rr_ptr wins last.
  always_comb begin
    int unsigned idx;
    arb_valid = 1'b0;
    arb_idx   = '0;
    idx       = 0;
    for (int i = NrHosts - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr_q) + i) % NrHosts;
      if (host_req_i[idx[HW-1:0]]) begin
        arb_valid = 1'b1;
        arb_idx   = idx[HW-1:0];
      end
    end
  end

  // Address decode of the winning host; downward walk makes lowest index win.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((host_addr_i[arb_idx] & cfg_device_addr_mask_i[d]) == cfg_device_addr_base_i[d]) begin
        dec_hit = 1'b1;
        dec_idx = DIW'(d);
      end
    end
  end

  // Only the device owning the transaction may complete it.
  assign rsp_valid = (state_q == WAIT_RSP) && device_rvalid_i[dev_q];

`ifdef SYS_BUS_RR_TIMEOUT_EN
  localparam int WdW = $clog2(TimeoutCycles + 1);
  logic [WdW-1:0] wdog_q, wdog_d;

  // Expiry loses to a real response arriving in the same cycle.
  assign timeout = (state_q == WAIT_RSP) && !rsp_valid && (wdog_q == WdW'(TimeoutCycles));

  // Watchdog counts silent WAIT_RSP cycles; zero everywhere else.
  always_comb begin
    wdog_d = '0;
    if (state_q == WAIT_RSP && !rsp_valid && !timeout) wdog_d = wdog_q + 1'b1;
  end

  // Watchdog register.
  always_ff @(posedge clk_i) begin
    if (rst_i) wdog_q <= '0;
    else       wdog_q <= wdog_d;
  end
`else
  logic unused_timeout;
  assign timeout        = 1'b0;
  assign unused_timeout = (TimeoutCycles > 0);
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      host_q   <= '0;
      dev_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      host_q   <= host_d;
      dev_q    <= dev_d;
    end
  end

  // Next-state: grant in IDLE, then wait for device or flag a decode miss.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    host_d   = host_q;
    dev_d    = dev_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          host_d   = arb_idx;
          dev_d    = dec_idx;
          rr_ptr_d = (int'(arb_idx) == NrHosts - 1) ? '0 : arb_idx + 1'b1;
          state_d  = dec_hit ? WAIT_RSP : ERR_RSP;
        end
      end
      WAIT_RSP: if (rsp_valid || timeout) state_d = IDLE;
      ERR_RSP:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs: all-zero unless carrying a grant/request or a response; reset masks all.
  always_comb begin
    host_gnt_o     = '0;
    host_rvalid_o  = '0;
    host_err_o     = '0;
    host_rdata_o   = '0;
    device_req_o   = '0;
    device_addr_o  = '0;
    device_we_o    = '0;
    device_be_o    = '0;
    device_wdata_o = '0;
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          if (arb_valid) begin
            host_gnt_o[arb_idx] = 1'b1;
            if (dec_hit) begin
              device_req_o[dec_idx]   = 1'b1;
              device_addr_o[dec_idx]  = host_addr_i[arb_idx];
              device_we_o[dec_idx]    = host_we_i[arb_idx];
              device_be_o[dec_idx]    = host_be_i[arb_idx];
              device_wdata_o[dec_idx] = host_wdata_i[arb_idx];
            end
          end
        end
        WAIT_RSP: begin
          if (rsp_valid) begin
            host_rvalid_o[host_q] = 1'b1;
            host_err_o[host_q]    = device_err_i[dev_q];
            host_rdata_o[host_q]  = device_rdata_i[dev_q];
          end else if (timeout) begin
            host_rvalid_o[host_q] = 1'b1;
            host_err_o[host_q]    = 1'b1;
          end
        end
        ERR_RSP: begin
          host_rvalid_o[host_q] = 1'b1;
          host_err_o[host_q]    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_bus_rr.sv
// tb_sys_bus_rr: directed scoreboard bench for sys_bus_rr (2 hosts, 4 devices).
// Watchdog scenarios use TimeoutCycles=4 when SYS_BUS_RR_TIMEOUT_EN is defined.
module tb_sys_bus_rr;
  localparam int NH = 2, ND = 4, DW = 32, AW = 32, TO = 4;

  logic                     clk, rst;
  logic [NH-1:0]            host_req, host_we, host_gnt, host_rvalid, host_err;
  logic [NH-1:0][AW-1:0]    host_addr;
  logic [NH-1:0][DW/8-1:0]  host_be;
  logic [NH-1:0][DW-1:0]    host_wdata, host_rdata;
  logic [ND-1:0]            dev_req, dev_we, dev_rvalid, dev_err;
  logic [ND-1:0][AW-1:0]    dev_addr, cfg_base, cfg_mask;
  logic [ND-1:0][DW/8-1:0]  dev_be;
  logic [ND-1:0][DW-1:0]    dev_wdata, dev_rdata;

  sys_bus_rr #(.NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW),
               .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
    .host_be_i(host_be), .host_wdata_i(host_wdata),
    .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid), .host_err_o(host_err),
    .host_rdata_o(host_rdata),
    .device_req_o(dev_req), .device_addr_o(dev_addr), .device_we_o(dev_we),
    .device_be_o(dev_be), .device_wdata_o(dev_wdata),
    .device_rvalid_i(dev_rvalid), .device_err_i(dev_err), .device_rdata_i(dev_rdata),
    .cfg_device_addr_base_i(cfg_base), .cfg_device_addr_mask_i(cfg_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NH-1:0]           gnt;
    logic [ND-1:0]           dreq;
    logic [ND-1:0][AW-1:0]   daddr;
    logic [ND-1:0]           dwe;
    logic [ND-1:0][DW/8-1:0] dbe;
    logic [ND-1:0][DW-1:0]   dwdata;
  } gnt_t;

  typedef struct {
    logic [NH-1:0]         rv;
    logic [NH-1:0]         err;
    logic [NH-1:0][DW-1:0] rdata;
  } rsp_t;

  gnt_t exp_gnt[$];
  rsp_t exp_rsp[$];
  int   checks = 0, errors = 0;
  logic rst_chk = 1'b0, end_chk = 1'b0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_host(input int h, input logic [AW-1:0] a, input logic we,
                            input logic [DW-1:0] wd);
    host_req[h]   = 1'b1;
    host_addr[h]  = a;
    host_we[h]    = we;
    host_be[h]    = we ? 4'b0011 : 4'b1111;
    host_wdata[h] = wd;
  endtask

  // Expected grant built from the host's current drive; dev<0 means decode miss.
  task automatic push_gnt(input int h, input int dev);
    gnt_t g;
    g.gnt = '0; g.dreq = '0; g.daddr = '0; g.dwe = '0; g.dbe = '0; g.dwdata = '0;
    g.gnt[h] = 1'b1;
    if (dev >= 0) begin
      g.dreq[dev]   = 1'b1;
      g.daddr[dev]  = host_addr[h];
      g.dwe[dev]    = host_we[h];
      g.dbe[dev]    = host_be[h];
      g.dwdata[dev] = host_wdata[h];
    end
    exp_gnt.push_back(g);
  endtask

  task automatic push_rsp(input int h, input logic e, input logic [DW-1:0] d);
    rsp_t r;
    r.rv = '0; r.err = '0; r.rdata = '0;
    r.rv[h] = 1'b1; r.err[h] = e; r.rdata[h] = d;
    exp_rsp.push_back(r);
  endtask

  task automatic respond(input int d, input logic [DW-1:0] data, input logic e);
    dev_rvalid[d] = 1'b1; dev_rdata[d] = data; dev_err[d] = e;
  endtask

  task automatic clear_dev();
    dev_rvalid = '0; dev_rdata = '0; dev_err = '0;
  endtask

  // Monitor: pops expectations whenever the DUT shows a grant or a response.
  always @(negedge clk) begin
    gnt_t g;
    rsp_t r;
    if (rst_chk) begin
      checks++;
      if (host_gnt !== '0 || host_rvalid !== '0 || host_err !== '0 || host_rdata !== '0 ||
          dev_req !== '0 || dev_addr !== '0 || dev_we !== '0 || dev_be !== '0 || dev_wdata !== '0) begin
        errors++;
        $display("FAIL reset_outputs: gnt=%b rvalid=%b err=%b dreq=%b, required all zero",
                 host_gnt, host_rvalid, host_err, dev_req);
      end
    end
    if (|host_gnt || |dev_req) begin
      checks++;
      if (exp_gnt.size() == 0) begin
        errors++;
        $display("FAIL unexpected_gnt: gnt=%b dreq=%b, required none", host_gnt, dev_req);
      end else begin
        g = exp_gnt.pop_front();
        if (host_gnt !== g.gnt || dev_req !== g.dreq || dev_addr !== g.daddr ||
            dev_we !== g.dwe || dev_be !== g.dbe || dev_wdata !== g.dwdata) begin
          errors++;
          $display("FAIL gnt: gnt=%b dreq=%b addr=%h we=%b be=%h wd=%h, required gnt=%b dreq=%b addr=%h we=%b be=%h wd=%h",
                   host_gnt, dev_req, dev_addr, dev_we, dev_be, dev_wdata,
                   g.gnt, g.dreq, g.daddr, g.dwe, g.dbe, g.dwdata);
        end
      end
    end
    if (|host_rvalid) begin
      checks++;
      if (exp_rsp.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: rvalid=%b err=%b rdata=%h, required none",
                 host_rvalid, host_err, host_rdata);
      end else begin
        r = exp_rsp.pop_front();
        if (host_rvalid !== r.rv || host_err !== r.err || host_rdata !== r.rdata) begin
          errors++;
          $display("FAIL rsp: rvalid=%b err=%b rdata=%h, required rvalid=%b err=%b rdata=%h",
                   host_rvalid, host_err, host_rdata, r.rv, r.err, r.rdata);
        end
      end
    end else if (host_err !== '0 || host_rdata !== '0) begin
      checks++;
      errors++;
      $display("FAIL idle_rsp: err=%b rdata=%h without rvalid, required zero", host_err, host_rdata);
    end
    if (end_chk) begin
      checks++;
      if (exp_gnt.size() != 0 || exp_rsp.size() != 0) begin
        errors++;
        $display("FAIL drain: pending gnt=%0d rsp=%0d, required 0 0", exp_gnt.size(), exp_rsp.size());
      end
    end
  end

  initial begin
    rst = 1'b1;
    host_req = '0; host_we = '0; host_addr = '0; host_be = '0; host_wdata = '0;
    clear_dev();
    // dev0 0x1xxxxx, dev1 0x2xxxxx, dev2 0x20xxxx (overlaps dev1), dev3 0x3xxxxx
    cfg_base[0] = 32'h0010_0000; cfg_mask[0] = 32'hFFF0_0000;
    cfg_base[1] = 32'h0020_0000; cfg_mask[1] = 32'hFFF0_0000;
    cfg_base[2] = 32'h0020_0000; cfg_mask[2] = 32'hFFFF_0000;
    cfg_base[3] = 32'h0030_0000; cfg_mask[3] = 32'hFFF0_0000;

    // Reset with live requests and responses: everything stays quiet.
    drive_host(0, 32'h0010_0000, 1'b0, '0);
    drive_host(1, 32'h0030_0000, 1'b1, 32'h1);
    dev_rvalid = '1;
    rst_chk = 1'b1;
    step(); step();
    rst_chk = 1'b0;
    host_req = '0;
    clear_dev();
    rst = 1'b0;
    step();

    // Both hosts requesting continuously: grants 0,1,0,1 with rsp between.
    drive_host(0, 32'h0010_0010, 1'b0, '0);
    drive_host(1, 32'h0030_0020, 1'b1, 32'hA5A5_0000);
    for (int k = 0; k < 4; k++) begin
      int h, d;
      h = k % 2;
      d = (h == 0) ? 0 : 3;
      push_gnt(h, d);
      step();
      respond(d, 32'h1000_0000 + k, 1'b0);
      push_rsp(h, 1'b0, 32'h1000_0000 + k);
      if (k == 3) host_req = '0;
      step();
      clear_dev();
    end

    // Host0 read hits dev0, one-cycle response.
    drive_host(0, 32'h0010_0004, 1'b0, '0);
    push_gnt(0, 0);
    step();
    host_req = '0;
    respond(0, 32'hDEAD_BEEF, 1'b0);
    push_rsp(0, 1'b0, 32'hDEAD_BEEF);
    step();
    clear_dev();

    // Host1 write to unmapped address: error next cycle; stray device rvalid ignored.
    drive_host(1, 32'h4000_0000, 1'b1, 32'h1234_5678);
    push_gnt(1, -1);
    step();
    host_req = '0;
    respond(0, 32'h0000_FFFF, 1'b0);
    push_rsp(1, 1'b1, '0);
    step();
    clear_dev();

    // Overlapping decode: dev1 wins over dev2; dev2 rvalid ignored; err forwarded.
    drive_host(0, 32'h0020_0040, 1'b0, '0);
    push_gnt(0, 1);
    step();
    host_req = '0;
    respond(2, 32'h0000_2222, 1'b0);
    step();
    clear_dev();
    respond(1, 32'h0000_BAD0, 1'b1);
    push_rsp(0, 1'b1, 32'h0000_BAD0);
    step();
    clear_dev();

    // Reset during WAIT_RSP aborts; later device rvalid produces nothing.
    drive_host(0, 32'h0010_0000, 1'b0, '0);
    push_gnt(0, 0);
    step();
    host_req = '0;
    rst = 1'b1;
    respond(0, 32'h0000_0077, 1'b0);
    step();
    rst = 1'b0;
    step();
    clear_dev();
    // rr_ptr back at 0: both requesting -> host0, then host1 alone.
    drive_host(0, 32'h0010_0008, 1'b0, '0);
    drive_host(1, 32'h0030_0004, 1'b0, '0);
    push_gnt(0, 0);
    step();
    host_req[0] = 1'b0;
    respond(0, 32'h0000_0088, 1'b0);
    push_rsp(0, 1'b0, 32'h0000_0088);
    step();
    clear_dev();
    push_gnt(1, 3);
    step();
    host_req = '0;
    respond(3, 32'h0000_0099, 1'b0);
    push_rsp(1, 1'b0, 32'h0000_0099);
    step();
    clear_dev();

`ifdef SYS_BUS_RR_TIMEOUT_EN
    // Silent device: error exactly 4 cycles after WAIT_RSP entry; late rvalid ignored.
    drive_host(0, 32'h0010_0000, 1'b0, '0);
    push_gnt(0, 0);
    step();
    host_req = '0;
    repeat (4) step();
    push_rsp(0, 1'b1, '0);
    step();
    respond(0, 32'h0000_0055, 1'b0);
    step();
    clear_dev();
    // Response in the expiry cycle wins over the timeout.
    drive_host(1, 32'h0030_0000, 1'b0, '0);
    push_gnt(1, 3);
    step();
    host_req = '0;
    repeat (4) step();
    respond(3, 32'h0000_5A5A, 1'b0);
    push_rsp(1, 1'b0, 32'h0000_5A5A);
    step();
    clear_dev();
`else
    // No watchdog: a slow device is still waited for.
    drive_host(0, 32'h0010_0000, 1'b0, '0);
    push_gnt(0, 0);
    step();
    host_req = '0;
    repeat (10) step();
    respond(0, 32'h00C0_FFEE, 1'b0);
    push_rsp(0, 1'b0, 32'h00C0_FFEE);
    step();
    clear_dev();
`endif

    step(); step();
    end_chk = 1'b1;
    @(negedge clk);
    #1;
    end_chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
